debounce_multi: RTL
===================

// Module: debounce_multi
//
// PURPOSE
// Multi-channel button conditioner for the calculator keypad and push-buttons.
// Each channel has its own 2-FF synchroniser and its own stability counter.
// Each channel outputs a debounced level, a one-cycle press pulse and a one-cycle release pulse.
// Optional auto-repeat re-fires press pulses while a key is held.
// Sits between the raw board inputs and the key-decode / calculator control FSM.
//
// PARAMETERS
// WIDTH        5     number of independent channels
// TICK_DIV     1000  i_clk cycles per timing tick (>=1); shared prescaler
// STABLE       20    ticks an input must disagree with o_btn before o_btn follows (>=1)
// REPEAT_EN    1     1: auto-repeat enabled; 0: exactly one press per hold
// REPEAT_DELAY 500   ticks held before first repeat press (>=1)
// REPEAT_RATE  100   ticks between subsequent repeat presses (>=1)
//
// PORTS
// i_clk      in   1      system clock
// i_rst      in   1      asynchronous, active-high reset
// i_btn      in   WIDTH  raw asynchronous button inputs (1 = pressed)
// o_btn      out  WIDTH  debounced level
// o_press    out  WIDTH  1-cycle pulse: debounced press or auto-repeat
// o_release  out  WIDTH  1-cycle pulse: debounced release
//
// BEHAVIOUR
// - Reset (async, i_rst=1): sync regs, all counters, prescaler, o_btn, o_press and o_release are all 0.
//   No pulses are generated on reset deassertion.
//   A key held through reset produces a normal press after STABLE ticks.
// - Sync: s[i] = i_btn[i] after 2 flops. The i_btn -> s latency is 2 cycles.
// - Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for one cycle when the count is TICK_DIV-1.
//   With TICK_DIV=1, tick is always 1.
// - Stability counter per channel (width $clog2(STABLE+1)):
//     * If s==o_btn, the counter clears to 0 on every cycle. Any single-cycle glitch restarts the count.
//     * If s!=o_btn and tick=1 and cnt==STABLE-1: o_btn<=s, cnt<=0, and the press/release pulse fires this edge.
//     * Otherwise, if s!=o_btn and tick=1: cnt<=cnt+1.
// - o_press/o_release are registered; they are asserted in the same cycle o_btn changes and are exactly 1 cycle wide.
// - Auto-repeat (REPEAT_EN=1) uses a per-channel hold counter, width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1):
//     * The hold counter loads REPEAT_DELAY when o_btn rises.
//     * While o_btn=1 and tick=1, it decrements.
//     * On the tick where it reaches 1: o_press pulses for 1 cycle and the counter reloads REPEAT_RATE.
//     * o_btn=0 clears it; no repeat pulse is possible after release.
//     * REPEAT_EN=0: this logic is removed and o_press fires only on rising o_btn.
// - Channels are fully independent. Several pulses in the same cycle are legal.
//   A press on channel i never affects channel j.
// - o_press and o_release are never both 1 for the same channel in the same cycle.
// - Latency with TICK_DIV=1, STABLE=1: i_btn edge -> o_btn/o_press is exactly 3 cycles.
//
// TESTING  (unless noted: WIDTH=2, TICK_DIV=4, STABLE=3, REPEAT_DELAY=5, REPEAT_RATE=2)
// 1. TICK_DIV=1, STABLE=1, REPEAT_EN=0: i_btn[0] 0->1 at cycle 0 -> o_btn[0]=1 and o_press[0]=1 at cycle 3.
//    o_press[0] is 0 at cycle 4.
// 2. Bounce: i_btn[0] toggles every 5 cycles for 60 cycles, then holds 1.
//    -> no o_btn/o_press change during the toggling.
//    -> o_btn[0] rises on the 3rd tick after the last edge reaches s, with one o_press.
// 3. Repeat: hold i_btn[0]=1 for 200 cycles.
//    -> o_press at debounce, again 5 ticks (20 cycles) later, then every 2 ticks (8 cycles).
//    Release -> one o_release after 3 ticks and no further o_press.
// 4. REPEAT_EN=0, same hold as test 3 -> exactly one o_press and exactly one o_release.
// 5. Both channels pressed in the same cycle -> o_press=2'b11 in one cycle.
//    A glitch on channel 1 (1-cycle low) does not delay channel 0 and does not release channel 1.
// 6. Assert i_rst mid-hold, asynchronously between edges -> all outputs 0 immediately, no pulse at deassert.
//    With the key still held, o_press returns after 3 ticks.

Source files
------------

// File: rtl/debounce_multi.sv
// debounce_multi: per-channel synchroniser, debouncer and press/release pulser
// for raw board buttons, with optional auto-repeat of press pulses while held.
//   i_clk      system clock
//   i_rst      asynchronous active-high reset
//   i_btn      raw asynchronous button levels (1 = pressed)
//   o_btn      debounced level
//   o_press    1-cycle pulse on debounced press or auto-repeat
//   o_release  1-cycle pulse on debounced release
module debounce_multi #(
  parameter int unsigned WIDTH        = 5,
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned STABLE       = 20,
  parameter int unsigned REPEAT_EN    = 1,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_btn,
  output logic [WIDTH-1:0] o_btn,
  output logic [WIDTH-1:0] o_press,
  output logic [WIDTH-1:0] o_release
);

  localparam int unsigned CNT_W = $clog2(STABLE + 1);
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [WIDTH-1:0] meta_q, sync_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_c;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] btn_q, btn_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;
  logic [WIDTH-1:0] chg_c;
  logic [WIDTH-1:0] rep_fire_c;

  // Two-flop synchroniser per channel
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_btn;
      sync_q <= meta_q;
    end
  end

  // Shared prescaler; with TICK_DIV=1 the compare is against 0 so tick is constant
  assign tick_c = (pre_q == PRE_W'(TICK_DIV - 1));

  always_comb begin
    pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
  end

  // chg_c: the debounced level flips on this edge
  always_comb begin
    chg_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      chg_c[i] = (sync_q[i] != btn_q[i]) && tick_c && (cnt_q[i] == CNT_W'(STABLE - 1));
    end
  end

  // Stability counters, debounced level and edge pulses
  always_comb begin
    btn_d     = btn_q ^ chg_c;
    press_d   = (chg_c & ~btn_q) | rep_fire_c;
    release_d = chg_c & btn_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((sync_q[i] == btn_q[i]) || chg_c[i]) begin
        cnt_d[i] = '0;
      end else if (tick_c) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pre_q     <= '0;
      btn_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      pre_q     <= pre_d;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Auto-repeat: hold counter per channel, fires when it is 1 on a tick
  if (REPEAT_EN != 0) begin : g_rep
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] hold_q [WIDTH];
    logic [HOLD_W-1:0] hold_d [WIDTH];

    always_comb begin
      rep_fire_c = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        hold_d[i] = hold_q[i];
        if (!btn_q[i]) begin
          hold_d[i] = chg_c[i] ? HOLD_W'(REPEAT_DELAY) : '0;
        end else if (chg_c[i]) begin
          // Releasing this edge: the release pulse wins, no repeat
          hold_d[i] = '0;
        end else if (tick_c) begin
          if (hold_q[i] == HOLD_W'(1)) begin
            rep_fire_c[i] = 1'b1;
            hold_d[i]     = HOLD_W'(REPEAT_RATE);
          end else if (hold_q[i] != '0) begin
            hold_d[i] = hold_q[i] - HOLD_W'(1);
          end
        end
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          hold_q[i] <= '0;
        end
      end else begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          hold_q[i] <= hold_d[i];
        end
      end
    end
  end else begin : g_norep
    assign rep_fire_c = '0;
  end

  assign o_btn     = btn_q;
  assign o_press   = press_q;
  assign o_release = release_q;

endmodule
